// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. Lookup is combinational on the fetch PC, so fetch can pick its
//   next PC in the same cycle. Resolved-branch updates from EX train the
//   tables on the rising clock edge.
//
//   Optional feature macro: BP_GSHARE_EN
//     undefined (default): one direction counter per BTB entry.
//     defined            : the counters move to a separate pattern table
//                          indexed by (pc index XOR global history).
module branch_target_predictor #(
  parameter int ADDR_WIDTH = 26,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Lookup side (fetch)
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic                  o_is_branch,
  output logic                  o_prediction,
  output logic [ADDR_WIDTH-1:0] o_target,
  // Maintenance and training side (EX)
  input  logic                  i_flush,
  input  logic                  i_update_valid,
  input  logic [ADDR_WIDTH-1:0] i_update_pc,
  input  logic                  i_update_branch,
  input  logic                  i_update_taken,
  input  logic [ADDR_WIDTH-1:0] i_update_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  // Saturating counter step: +1 up to 3 when taken, -1 down to 0 otherwise.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];

`ifdef BP_GSHARE_EN
  logic [1:0]            pht_q    [ENTRIES];
  logic [INDEX_BITS-1:0] ghr_q;
`else
  logic [1:0]            ctr_q    [ENTRIES];
`endif

  // ---------------------------------------------------------------------------
  // Lookup decode
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;
  logic [1:0]            lk_ctr;

  assign lk_idx = i_pc[INDEX_BITS+1:2];
  assign lk_tag = i_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

`ifdef BP_GSHARE_EN
  assign lk_ctr = pht_q[lk_idx ^ ghr_q];
`else
  assign lk_ctr = ctr_q[lk_idx];
`endif

  // Outputs are forced to zero on a miss so fetch never sees stale targets.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    o_is_branch  = 1'b0;
    o_prediction = 1'b0;
    o_target     = '0;
    if (lk_hit) begin
      o_is_branch  = 1'b1;
      o_prediction = lk_ctr[1];
      o_target     = target_q[lk_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Update decode
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;
  logic                  up_en;        // update accepted (flush drops it)
  logic                  up_br_en;     // accepted update of a control transfer

  assign up_idx   = i_update_pc[INDEX_BITS+1:2];
  assign up_tag   = i_update_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en    = i_update_valid && !i_flush;
  assign up_br_en = up_en && i_update_branch;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_low_bits;
  assign unused_low_bits = ^{i_pc[1:0], i_update_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Valid bits: cleared by reset and flush, set on branch allocation, cleared
  // when a non-branch aliases onto a live entry.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is written with non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      valid_q <= '0;
    end else if (i_flush) begin
      valid_q <= '0;
    end else if (i_update_valid) begin
      if (i_update_branch)  valid_q[up_idx] <= 1'b1;
      else if (up_hit)      valid_q[up_idx] <= 1'b0;
    end
  end

  // Tag and target RAM: written on every accepted branch update.
  always_ff @(posedge clk) begin
    // NOTE: tag and target are deliberately not reset; valid_q gates every use
    // of them, so resetting these arrays would only cost reset routing.
    if (up_br_en) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= i_update_target;
    end
  end

`ifdef BP_GSHARE_EN
  // ---------------------------------------------------------------------------
  // Gshare direction state: pattern table trained at (index ^ pre-shift ghr)
  // on every branch update; allocation does not reinitialise the counter.
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] up_pht_idx;
  assign up_pht_idx = up_idx ^ ghr_q;

  // Pattern table counters: reset to weakly not-taken, untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_WEAK_NT;
    end else if (up_br_en) begin
      pht_q[up_pht_idx] <= ctr_step(pht_q[up_pht_idx], i_update_taken);
    end
  end

  // Global history: shifts in the outcome of every branch update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (i_flush) begin
      ghr_q <= '0;
    end else if (up_br_en) begin
      ghr_q <= {ghr_q[INDEX_BITS-2:0], i_update_taken};
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Per-entry direction counters: trained on a hit, reinitialised on allocate.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WEAK_NT;
    end else if (up_br_en) begin
      if (up_hit)              ctr_q[up_idx] <= ctr_step(ctr_q[up_idx], i_update_taken);
      else if (i_update_taken) ctr_q[up_idx] <= CTR_WEAK_T;
      else                     ctr_q[up_idx] <= CTR_WEAK_NT;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor
//   Scoreboard bench: the driver computes the expected lookup response from a
//   behavioural table model and queues it; a monitor on the falling edge pops
//   and compares against the DUT. Directed scenarios come first, followed by
//   randomized traffic with occasional flushes and mid-run resets.
module tb_branch_target_predictor;

  localparam int AW      = 26;
  localparam int IB      = 6;
  localparam int ENTRIES = 1 << IB;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] i_pc;
  logic          o_is_branch;
  logic          o_prediction;
  logic [AW-1:0] o_target;
  logic          i_flush;
  logic          i_update_valid;
  logic [AW-1:0] i_update_pc;
  logic          i_update_branch;
  logic          i_update_taken;
  logic [AW-1:0] i_update_target;

  branch_target_predictor #(.ADDR_WIDTH(AW), .INDEX_BITS(IB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_pc            (i_pc),
    .o_is_branch     (o_is_branch),
    .o_prediction    (o_prediction),
    .o_target        (o_target),
    .i_flush         (i_flush),
    .i_update_valid  (i_update_valid),
    .i_update_pc     (i_update_pc),
    .i_update_branch (i_update_branch),
    .i_update_taken  (i_update_taken),
    .i_update_target (i_update_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a table of entries with integer counters
  // ---------------------------------------------------------------------------
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
`ifdef BP_GSHARE_EN
  int          m_pht    [ENTRIES];
  int          m_ghr;
`endif

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc >> (IB + 2);
  endfunction

  function automatic int bump(input int c, input bit taken);
    if (taken) return (c < 3) ? c + 1 : 3;
    else       return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
`ifdef BP_GSHARE_EN
      m_pht[i]   = 1;
`endif
    end
`ifdef BP_GSHARE_EN
    m_ghr = 0;
`endif
  endtask

  typedef struct {
    logic          is_branch;
    logic          prediction;
    logic [AW-1:0] target;
  } exp_t;

  function automatic exp_t model_lookup(input int unsigned pc);
    exp_t e;
    int unsigned i;
    int c;
    i = idx_of(pc);
    e.is_branch  = 1'b0;
    e.prediction = 1'b0;
    e.target     = '0;
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
`ifdef BP_GSHARE_EN
      c = m_pht[i ^ m_ghr];
`else
      c = m_ctr[i];
`endif
      e.is_branch  = 1'b1;
      e.prediction = (c >= 2);
      e.target     = m_target[i][AW-1:0];
    end
    return e;
  endfunction

  task automatic model_update(input int unsigned pc, input bit uv, input bit ub,
                              input bit ut, input int unsigned tgt, input bit fl);
    int unsigned i;
    bit hit;
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
`ifdef BP_GSHARE_EN
      m_ghr = 0;
`endif
      return;
    end
    if (!uv) return;
    i   = idx_of(pc);
    hit = m_valid[i] && m_tag[i] == tag_of(pc);
    if (ub) begin
`ifdef BP_GSHARE_EN
      m_pht[i ^ m_ghr] = bump(m_pht[i ^ m_ghr], ut);
      m_ghr = ((m_ghr << 1) | int'(ut)) % ENTRIES;
`endif
      m_ctr[i]    = hit ? bump(m_ctr[i], ut) : (ut ? 2 : 1);
      m_valid[i]  = 1'b1;
      m_tag[i]    = tag_of(pc);
      m_target[i] = tgt;
    end else if (hit) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard queue and monitor
  // ---------------------------------------------------------------------------
  exp_t exp_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("is_branch",  32'(o_is_branch),  32'(e.is_branch));
        check("prediction", 32'(o_prediction), 32'(e.prediction));
        check("target",     32'(o_target),     32'(e.target));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change #1 after the rising edge
  // ---------------------------------------------------------------------------
  task automatic drive(input int unsigned pc, input bit uv, input bit ub, input bit ut,
                       input int unsigned tgt, input bit fl);
    i_pc            = pc[AW-1:0];
    i_update_valid  = uv;
    i_update_pc     = pc[AW-1:0];
    i_update_branch = ub;
    i_update_taken  = ut;
    i_update_target = tgt[AW-1:0];
    i_flush         = fl;
    exp_q.push_back(model_lookup(pc));
    model_update(pc, uv, ub, ut, tgt, fl);
    @(posedge clk);
    #1;
  endtask

  // Lookup at one PC while updating another.
  task automatic drive2(input int unsigned lk_pc, input int unsigned up_pc, input bit uv,
                        input bit ub, input bit ut, input int unsigned tgt, input bit fl);
    i_pc            = lk_pc[AW-1:0];
    i_update_valid  = uv;
    i_update_pc     = up_pc[AW-1:0];
    i_update_branch = ub;
    i_update_taken  = ut;
    i_update_target = tgt[AW-1:0];
    i_flush         = fl;
    exp_q.push_back(model_lookup(lk_pc));
    model_update(up_pc, uv, ub, ut, tgt, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int unsigned pc);
    drive2(pc, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Reset asserted mid-cycle with an update pending; the sample taken later in
  // the same cycle must already show an empty predictor.
  task automatic do_reset(input int unsigned pc);
    exp_t z;
    z.is_branch  = 1'b0;
    z.prediction = 1'b0;
    z.target     = '0;
    rst_n           = 1'b0;
    i_pc            = pc[AW-1:0];
    i_update_valid  = 1'b1;
    i_update_pc     = pc[AW-1:0];
    i_update_branch = 1'b1;
    i_update_taken  = 1'b1;
    i_update_target = 26'h0ABCDE;
    i_flush         = 1'b0;
    exp_q.push_back(z);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int unsigned rand_pc();
    int unsigned t, i, lo;
    t  = $urandom_range(0, 3);
    i  = $urandom_range(0, 7);
    lo = $urandom_range(0, 3);
    return (t << (IB + 2)) | (i << 2) | lo;
  endfunction

  // Watchdog: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    i_pc = '0; i_flush = 1'b0; i_update_valid = 1'b0; i_update_pc = '0;
    i_update_branch = 1'b0; i_update_taken = 1'b0; i_update_target = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state seen before any edge.
    do_reset('h40);
    lookup('h40);

    // Allocate 0x40 taken -> hit, predict taken, target 0x100.
    drive2('h0, 'h40, 1, 1'b1, 1'b1, 'h100, 1'b0);
    lookup('h40);

    // Saturation: three not-taken updates, lookup sees pre-update state.
    for (int k = 0; k < 3; k++) drive('h40, 1, 1'b1, 1'b0, 'h100, 1'b0);
    lookup('h40);

    // Alias eviction by a branch, then by a non-branch.
    drive2('h0, 'h140, 1, 1'b1, 1'b1, 'h200, 1'b0);
    lookup('h40);
    lookup('h140);
    drive2('h0, 'h140, 1, 1'b0, 1'b0, 'h0, 1'b0);
    lookup('h140);

    // Flush wins over a same-cycle allocation.
    drive2('h0, 'h40, 1, 1'b1, 1'b1, 'h300, 1'b0);
    drive2('h40, 'h80, 1, 1'b1, 1'b1, 'h400, 1'b1);
    lookup('h40);
    lookup('h80);

    // Same-cycle read/write: miss now, hit next cycle.
    drive('h80, 1, 1'b1, 1'b1, 'h500, 1'b0);
    lookup('h80);

    // Alternating not-taken/taken at 0x40 (history training).
    for (int k = 0; k < 6; k++) drive('h40, 1, 1'b1, k[0], 'h600, 1'b0);
    lookup('h40);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset(rand_pc());
      end else begin
        drive2(rand_pc(), rand_pc(), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7),
               1'($urandom), $urandom & 32'h03FF_FFFF, (r < 4));
      end
    end

    i_update_valid = 1'b0;
    i_flush        = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
